// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by the sequential ALU.
package alu_pkg;
    typedef enum logic [3:0] {
        OP_INC_A, OP_INC_B, OP_PASS_A, OP_PASS_B,
        OP_DEC_A, OP_MUL,   OP_ADD,    OP_SUB,
        OP_NEG_A, OP_NEG_B, OP_AND,    OP_OR,
        OP_XOR,   OP_XNOR,  OP_NAND,   OP_NOR
    } alu_op_e;
    typedef enum logic [0:0] {ST_IDLE, ST_MUL} alu_state_e;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: command and result handshake bundle for alu_seq.
interface alu_seq_if #(
    parameter int W = 8
);
    logic           in_valid, in_ready;
    logic [W-1:0]   a, b;
    logic [3:0]     sel;
    logic           out_valid, out_ready;
    logic [2*W-1:0] y;
    logic           zero, carry, busy;
    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, y, zero, carry, busy
    );
    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, y, zero, carry, busy
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier; done_o and prod_o present the
// final iteration combinationally so the caller can register it on that edge.
module alu_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] prod_o
);
    localparam int CW = $clog2(W);
    logic [2*W-1:0] mcand_q, acc_q, acc_d;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;

    assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign done_o = run_q && cnt_q == CW'(W - 1);
    assign prod_o = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + 1'b1;
            run_q    <= !done_o;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops register in one edge, MUL runs
// through alu_mul_seq while the command side is held off.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave io
);
    logic [2*W-1:0] a2, b2, res, prod, y_q, y_d;
    logic           res_c, accept, start, mul_done;
    logic           ov_q, ov_d, zero_q, zero_d, carry_q, carry_d;
    alu_op_e        op;
    alu_state_e     state_q, state_d;

    assign op          = alu_op_e'(io.sel);
    assign a2          = {{W{1'b0}}, io.a};
    assign b2          = {{W{1'b0}}, io.b};
    assign io.in_ready = !rst && state_q == ST_IDLE && (!ov_q || io.out_ready);
    assign accept      = io.in_valid && io.in_ready;
    assign start       = accept && op == OP_MUL;
    assign io.out_valid = ov_q;
    assign io.y        = y_q;
    assign io.zero     = zero_q;
    assign io.carry    = carry_q;
    assign io.busy     = state_q == ST_MUL;

    alu_mul_seq #(.W(W)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start_i(start),
        .a_i    (io.a),
        .b_i    (io.b),
        .done_o (mul_done),
        .prod_o (prod)
    );

    // Carry of add-type ops is bit W of the zero-extended 2W-bit sum.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (op)
            OP_INC_A:  begin res = a2 + 1'b1; res_c = res[W]; end
            OP_INC_B:  begin res = b2 + 1'b1; res_c = res[W]; end
            OP_PASS_A: res = a2;
            OP_PASS_B: res = b2;
            OP_DEC_A:  begin res = a2 - 1'b1; res_c = io.a == '0; end
            OP_MUL:    res = '0;
            OP_ADD:    begin res = a2 + b2; res_c = res[W]; end
            OP_SUB:    begin res = a2 - b2; res_c = io.a < io.b; end
            OP_NEG_A:  res = ~a2 + 1'b1;
            OP_NEG_B:  res = ~b2 + 1'b1;
            OP_AND:    res = a2 & b2;
            OP_OR:     res = a2 | b2;
            OP_XOR:    res = a2 ^ b2;
            OP_XNOR:   res = ~(a2 ^ b2);
            OP_NAND:   res = ~(a2 & b2);
            OP_NOR:    res = ~(a2 | b2);
        endcase
    end

    always_comb begin
        state_d = start ? ST_MUL : state_q;
        y_d     = y_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ov_d    = ov_q && !io.out_ready;
        if (accept && op != OP_MUL) begin
            y_d     = res;
            zero_d  = res == '0;
            carry_d = res_c;
            ov_d    = 1'b1;
        end
        if (state_q == ST_MUL && mul_done) begin
            y_d     = prod;
            zero_d  = prod == '0;
            carry_d = 1'b0;
            ov_d    = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ov_q    <= ov_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors, MUL timing, backpressure, streaming and reset
// abort for alu_seq at W=4, with a scoreboard on every output transfer.
module tb_alu_seq;
    localparam int W = 4;
    typedef struct {
        logic [3:0]     sel;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] y;
        logic           zero, carry;
    } vec_t;
    typedef struct {
        logic [2*W-1:0] y;
        logic           zero, carry;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0, total_cnt = 0;
    exp_t sb[$];
    vec_t vecs[18];

    alu_seq_if #(.W(W)) io ();
    alu_seq #(.W(W)) dut (.clk(clk), .rst(rst), .io(io));

    always #5 clk = ~clk;

    function automatic exp_t model(logic [3:0] sel, logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        r = 0;
        e.carry = 1'b0;
        case (sel)
            4'd0:  begin r = ia + 1;  e.carry = r >= (1 << W); end
            4'd1:  begin r = ib + 1;  e.carry = r >= (1 << W); end
            4'd2:  r = ia;
            4'd3:  r = ib;
            4'd4:  begin r = ia - 1;  e.carry = ia == 0; end
            4'd5:  r = ia * ib;
            4'd6:  begin r = ia + ib; e.carry = r >= (1 << W); end
            4'd7:  begin r = ia - ib; e.carry = ia < ib; end
            4'd8:  r = -ia;
            4'd9:  r = -ib;
            4'd10: r = ia & ib;
            4'd11: r = ia | ib;
            4'd12: r = ia ^ ib;
            4'd13: r = ~(ia ^ ib);
            4'd14: r = ~(ia & ib);
            4'd15: r = ~(ia | ib);
            default: r = 0;
        endcase
        e.y = r[2*W-1:0];
        e.zero = e.y == '0;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [3:0] sel, logic [W-1:0] a, logic [W-1:0] b);
        int n;
        n = 0;
        io.sel = sel;
        io.a = a;
        io.b = b;
        io.in_valid = 1'b1;
        #1;
        while (!io.in_ready && n < 50) begin
            tick;
            n++;
        end
        if (!io.in_ready) chk("send_timeout", 0, 1);
        tick;
        io.in_valid = 1'b0;
    endtask

    task automatic mul_check(logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] y, logic z);
        int lat, low;
        send(4'd5, a, b);
        lat = 1;
        low = 0;
        while (!io.out_valid && lat < 20) begin
            if (!io.in_ready && io.busy) low++;
            tick;
            lat++;
        end
        chk("mul_latency", lat, W + 1);
        chk("mul_busy_cycles", low, W);
        chk("mul_y", io.y, y);
        chk("mul_zero", io.zero, z);
        chk("mul_carry", io.carry, 0);
        chk("mul_busy_done", io.busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (io.out_valid && io.out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_y", io.y, e.y);
                    chk("sb_zero", io.zero, e.zero);
                    chk("sb_carry", io.carry, e.carry);
                end
            end
            if (io.in_valid && io.in_ready) sb.push_back(model(io.sel, io.a, io.b));
        end
    end

    initial begin
        int hi, rdy, sent, cyc;
        logic acc;
        logic [3:0] s;
        rst = 1'b1;
        io.in_valid = 1'b0;
        io.a = '0;
        io.b = '0;
        io.sel = '0;
        io.out_ready = 1'b1;
        vecs = '{
            '{4'd6,  4'd15, 4'd15, 8'h1E, 1'b0, 1'b1},
            '{4'd8,  4'd3,  4'd0,  8'hFD, 1'b0, 1'b0},
            '{4'd13, 4'd5,  4'd3,  8'hF9, 1'b0, 1'b0},
            '{4'd7,  4'd2,  4'd5,  8'hFD, 1'b0, 1'b1},
            '{4'd4,  4'd0,  4'd0,  8'hFF, 1'b0, 1'b1},
            '{4'd10, 4'd5,  4'd10, 8'h00, 1'b1, 1'b0},
            '{4'd0,  4'd15, 4'd0,  8'h10, 1'b0, 1'b1},
            '{4'd1,  4'd0,  4'd3,  8'h04, 1'b0, 1'b0},
            '{4'd2,  4'd9,  4'd0,  8'h09, 1'b0, 1'b0},
            '{4'd3,  4'd0,  4'd12, 8'h0C, 1'b0, 1'b0},
            '{4'd9,  4'd0,  4'd0,  8'h00, 1'b1, 1'b0},
            '{4'd11, 4'd5,  4'd10, 8'h0F, 1'b0, 1'b0},
            '{4'd12, 4'd15, 4'd15, 8'h00, 1'b1, 1'b0},
            '{4'd14, 4'd15, 4'd15, 8'hF0, 1'b0, 1'b0},
            '{4'd15, 4'd0,  4'd0,  8'hFF, 1'b0, 1'b0},
            '{4'd6,  4'd7,  4'd8,  8'h0F, 1'b0, 1'b0},
            '{4'd4,  4'd1,  4'd0,  8'h00, 1'b1, 1'b0},
            '{4'd7,  4'd5,  4'd5,  8'h00, 1'b1, 1'b0}
        };
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", io.in_ready, 0);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_y", io.y, 0);
        chk("rst_zero", io.zero, 0);
        chk("rst_carry", io.carry, 0);
        chk("rst_busy", io.busy, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", io.in_ready, 1);

        foreach (vecs[i]) begin
            send(vecs[i].sel, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_valid", i), io.out_valid, 1);
            chk($sformatf("vec%0d_y", i), io.y, vecs[i].y);
            chk($sformatf("vec%0d_zero", i), io.zero, vecs[i].zero);
            chk($sformatf("vec%0d_carry", i), io.carry, vecs[i].carry);
        end

        mul_check(4'd15, 4'd15, 8'hE1, 1'b0);
        mul_check(4'd0, 4'd9, 8'h00, 1'b1);
        mul_check(4'd15, 4'd1, 8'h0F, 1'b0);

        send(4'd6, 4'd9, 4'd9);
        io.out_ready = 1'b0;
        io.sel = 4'd0;
        io.a = 4'd7;
        io.in_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("bp_valid", io.out_valid, 1);
            chk("bp_y", io.y, 8'h12);
            chk("bp_carry", io.carry, 1);
            chk("bp_zero", io.zero, 0);
            chk("bp_in_ready", io.in_ready, 0);
            tick;
        end
        io.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", io.in_ready, 1);
        tick;
        io.in_valid = 1'b0;
        chk("bp_next_valid", io.out_valid, 1);
        chk("bp_next_y", io.y, 8'h08);

        hi = 0;
        rdy = 0;
        for (int i = 0; i < 16; i++) begin
            do s = 4'($urandom_range(0, 15)); while (s == 4'd5);
            io.sel = s;
            io.a = W'($urandom_range(0, 15));
            io.b = W'($urandom_range(0, 15));
            io.in_valid = 1'b1;
            #1;
            if (io.in_ready) rdy++;
            tick;
            if (io.out_valid) hi++;
        end
        io.in_valid = 1'b0;
        chk("stream_in_ready", rdy, 16);
        chk("stream_valid_cycles", hi, 16);
        tick;
        chk("stream_drained", sb.size(), 0);

        sent = 0;
        cyc = 0;
        while ((sent < 16 || sb.size() != 0 || io.out_valid) && cyc < 600) begin
            if (!io.in_valid && sent < 16) begin
                io.sel = 4'($urandom_range(0, 15));
                io.a = W'($urandom_range(0, 15));
                io.b = W'($urandom_range(0, 15));
                io.in_valid = 1'b1;
            end
            io.out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = io.in_valid && io.in_ready;
            tick;
            cyc++;
            if (acc) begin
                io.in_valid = 1'b0;
                sent++;
            end
        end
        chk("rand_sent", sent, 16);
        chk("rand_drained", sb.size(), 0);
        io.out_ready = 1'b1;

        send(4'd5, 4'd6, 4'd7);
        tick;
        tick;
        #3;
        rst = 1'b1;
        #1;
        chk("abort_y", io.y, 0);
        chk("abort_valid", io.out_valid, 0);
        chk("abort_busy", io.busy, 0);
        chk("abort_zero", io.zero, 0);
        chk("abort_carry", io.carry, 0);
        chk("abort_in_ready", io.in_ready, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        hi = 0;
        repeat (8) begin
            tick;
            if (io.out_valid) hi++;
        end
        chk("abort_no_result", hi, 0);
        send(4'd6, 4'd1, 4'd2);
        chk("post_rst_valid", io.out_valid, 1);
        chk("post_rst_y", io.y, 8'h03);
        chk("post_rst_carry", io.carry, 0);
        tick;
        chk("final_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
